phy_link_ctrl: RTL and testbench
================================

# phy_link_ctrl

Link-bring-up controller for the two-lane PCI PHY. It qualifies the per-lane `active_serial_paralelo_0/1` indications from the RX serial-to-parallel stages, drives the combined `link_up` that gates the TX recirculator (replacing the plain AND of the actives), and gates `valid` into the TX path. On lane loss it retries recovery a bounded number of times, then declares failure.

## Interface
- `STABLE_CYCLES`, default 8: consecutive both-active samples required before link up (≥2).
- `RECOVER_CYCLES`, default 16: cycles per recovery attempt before timeout (≥2).
- `MAX_RETRIES`, default 3: timeouts allowed before FAIL (1–15).
- `CNT_W`, default 8: width of `drop_count`.
- `clk_f`  input  1  sole clock, rising edge; all state registered on it.
- `reset`  input  1  asynchronous, active-high; all registers clear immediately.
- `train_en`  input  1  1 = run link training; 0 = force IDLE.
- `active_serial_paralelo_0`  input  1  lane 0 RX active.
- `active_serial_paralelo_1`  input  1  lane 1 RX active.
- `valid`  input  1  upstream data valid.
- `link_up`  output  1  1 iff state == UP; drives the TX recirculator active select.
- `valid_tx`  output  1  registered `valid` gated by link up.
- `retrain`  output  1  one-cycle pulse requesting lane re-sync.
- `link_fail`  output  1  1 iff state == FAIL.
- `state`  output  3  IDLE=0, WAIT=1, STABLE=2, UP=3, RECOVER=4, FAIL=5.
- `drop_count`  output  CNT_W  saturating count of `valid` cycles lost while not UP.

## Operation
- Internal: `stable_cnt` (counts to STABLE_CYCLES), `timer` (counts to RECOVER_CYCLES-1), `retries` (4 bits). `both` = active_0 & active_1.
- Priority: `reset` > `train_en`=0 > per-state rules. `train_en`=0 in any state → IDLE next edge, counters cleared, no `retrain` pulse.
- IDLE: `train_en`=1 → WAIT.
- WAIT: `both` → STABLE, `stable_cnt`=1; else stay.
- STABLE: `both` low → WAIT, `stable_cnt`=0. `both` high: `stable_cnt`+1; when the increment reaches STABLE_CYCLES → UP, `retries`=0.
- UP: `both` low → RECOVER, `timer`=0, `retrain` pulse.
- RECOVER: `both` high → STABLE, `stable_cnt`=1 (full requalification). Else `timer`+1; at `timer`==RECOVER_CYCLES-1: `retries`+1, `timer`=0; if new `retries`==MAX_RETRIES → FAIL (no pulse), else stay in RECOVER with another `retrain` pulse.
- Same-edge conflict in RECOVER (timeout and `both` high): `both` wins → STABLE, `retries` unchanged.
- FAIL: sticky; exit only via `train_en`=0 or `reset`.
- `valid_tx` <= `valid` & (state==UP), evaluated on the current (pre-edge) state.
- `drop_count` += 1 on each edge with `valid`=1 and state≠UP; saturates at 2^CNT_W-1; cleared only by `reset`.

## Timing
- Reset values: state IDLE, `link_up`/`valid_tx`/`retrain`/`link_fail` 0, `drop_count` 0, internal counters 0.
- All outputs registered; no combinational input-to-output path.
- Bring-up: `train_en` high before edge 0 → WAIT after edge 0. `both` high from edge 1 → STABLE after edge 1; `link_up`=1 after edge STABLE_CYCLES (STABLE_CYCLES consecutive both-high samples).
- A single low `both` sample in STABLE restarts qualification from WAIT.
- Lane drop sampled at edge k in UP: `link_up`=0 and `retrain`=1 after edge k; `retrain`=0 after edge k+1.
- Retry pulses every RECOVER_CYCLES cycles; FAIL entered RECOVER_CYCLES·MAX_RETRIES edges after entering RECOVER.
- `valid_tx` lags `valid` by one cycle; first `valid_tx` possible the edge after `link_up` rises.
- Asynchronous `reset` mid-operation clears everything immediately, including `drop_count`; `retrain` never glitches.

## Test plan
- Bring-up (defaults): reset, `train_en`=1, both actives high from edge 1 → `link_up`=1 after edge 8, `state`=3, `retrain` never high.
- Glitch in qualification: active_1 low for one cycle at STABLE sample 5 → back to WAIT; `link_up` rises only after 8 further consecutive both-high samples.
- Recovery success: in UP, drop active_0 for 5 cycles → `retrain` one-cycle pulse, `state`=4; actives return → STABLE, `link_up`=1 eight samples later, `retries`=0.
- Retry exhaustion: in UP, hold active_0 low → `retrain` pulses after entry, then at +16 and +32 cycles; `link_fail`=1 and `state`=5 at +48; `train_en`=0 → IDLE next edge.
- Data gating: `valid`=1 constantly from reset with CNT_W=4 → `drop_count` saturates at 15; `valid_tx`=1 starting one edge after `link_up` rises, drops one edge after `link_up` falls.
- Priority: in UP, `train_en`→0 on the same edge a lane drops → IDLE, no `retrain`; async `reset` pulse mid-RECOVER → all outputs 0 immediately.

Source files
------------

// File: rtl/phy_link_ctrl_if.sv
// Purpose: bundles the lane/data inputs and link status outputs of phy_link_ctrl.
// Latency: none (wires only); every output is driven from a register in the controller.
// Backpressure: none; valid is gated, not stalled, by the controller.
interface phy_link_ctrl_if #(
  parameter int CNT_W = 8
);
  // Stimulus side
  logic             train_en;
  logic             active_serial_paralelo_0;
  logic             active_serial_paralelo_1;
  logic             valid;
  // Status side
  logic             link_up;
  logic             valid_tx;
  logic             retrain;
  logic             link_fail;
  logic [2:0]       state;
  logic [CNT_W-1:0] drop_count;

  // Upstream/PHY side driving training controls and observing link status
  modport master (
    output train_en,
    output active_serial_paralelo_0,
    output active_serial_paralelo_1,
    output valid,
    input  link_up,
    input  valid_tx,
    input  retrain,
    input  link_fail,
    input  state,
    input  drop_count
  );

  // Controller side
  modport slave (
    input  train_en,
    input  active_serial_paralelo_0,
    input  active_serial_paralelo_1,
    input  valid,
    output link_up,
    output valid_tx,
    output retrain,
    output link_fail,
    output state,
    output drop_count
  );
endinterface

// File: rtl/phy_link_ctrl.sv
// Purpose: two-lane link bring-up FSM with bounded recovery, link_up/valid gating and drop counting.
// Latency: all outputs registered; state changes and valid_tx appear one clk_f edge after sampling.
// Backpressure: none; valid seen while the link is not UP is discarded and counted in drop_count.
module phy_link_ctrl #(
  parameter int STABLE_CYCLES  = 8,
  parameter int RECOVER_CYCLES = 16,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 8
) (
  input  logic          clk_f,
  input  logic          reset,
  phy_link_ctrl_if.slave lnk
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_STABLE  = 3'd2,
    ST_UP      = 3'd3,
    ST_RECOVER = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

  // stable_cnt must be able to hold STABLE_CYCLES itself; timer only reaches RECOVER_CYCLES-1.
  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam int TM_W = $clog2(RECOVER_CYCLES);

  localparam logic [SC_W-1:0]  STABLE_TARGET = SC_W'(STABLE_CYCLES);
  localparam logic [SC_W-1:0]  STABLE_ONE    = SC_W'(1);
  localparam logic [TM_W-1:0]  TIMER_LAST    = TM_W'(RECOVER_CYCLES - 1);
  localparam logic [TM_W-1:0]  TIMER_ONE     = TM_W'(1);
  localparam logic [3:0]       RETRY_LIMIT   = 4'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] DROP_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DROP_ONE      = CNT_W'(1);

  state_e           state_q,      state_d;
  logic [SC_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic [TM_W-1:0]  timer_q,      timer_d;
  logic [3:0]       retries_q,    retries_d;
  logic             retrain_q,    retrain_d;
  logic             valid_tx_q,   valid_tx_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic             both;
  logic [SC_W-1:0]  stable_inc;
  logic [3:0]       retries_inc;

  assign both        = lnk.active_serial_paralelo_0 & lnk.active_serial_paralelo_1;
  assign stable_inc  = stable_cnt_q + STABLE_ONE;
  assign retries_inc = retries_q + 4'd1;

  // Next-state, counter and retrain-pulse decode for the training FSM.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    timer_d      = timer_q;
    retries_d    = retries_q;
    retrain_d    = 1'b0;

    if (!lnk.train_en) begin
      // Training disabled overrides everything below; no retrain request on the way out.
      state_d      = ST_IDLE;
      stable_cnt_d = '0;
      timer_d      = '0;
      retries_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
        end

        ST_WAIT: begin
          if (both) begin
            state_d      = ST_STABLE;
            stable_cnt_d = STABLE_ONE;
          end
        end

        ST_STABLE: begin
          if (!both) begin
            // Any gap restarts qualification from scratch.
            state_d      = ST_WAIT;
            stable_cnt_d = '0;
          end else if (stable_inc == STABLE_TARGET) begin
            state_d      = ST_UP;
            stable_cnt_d = '0;
            retries_d    = '0;
          end else begin
            stable_cnt_d = stable_inc;
          end
        end

        ST_UP: begin
          if (!both) begin
            state_d   = ST_RECOVER;
            timer_d   = '0;
            retrain_d = 1'b1;
          end
        end

        ST_RECOVER: begin
          if (both) begin
            // Lanes back: requalify fully. Takes precedence over a same-edge timeout,
            // so retries is left untouched here.
            state_d      = ST_STABLE;
            stable_cnt_d = STABLE_ONE;
          end else if (timer_q == TIMER_LAST) begin
            timer_d   = '0;
            retries_d = retries_inc;
            if (retries_inc == RETRY_LIMIT) begin
              state_d = ST_FAIL;
            end else begin
              retrain_d = 1'b1;
            end
          end else begin
            timer_d = timer_q + TIMER_ONE;
          end
        end

        ST_FAIL: begin
          state_d = ST_FAIL;
        end

        default: begin
          state_d      = ST_IDLE;
          stable_cnt_d = '0;
          timer_d      = '0;
          retries_d    = '0;
        end
      endcase
    end
  end

  // Data-path gating and lost-valid accounting, both keyed on the pre-edge state.
  always_comb begin
    valid_tx_d   = lnk.valid & (state_q == ST_UP);
    drop_count_d = drop_count_q;
    if (lnk.valid && (state_q != ST_UP) && (drop_count_q != DROP_MAX)) begin
      drop_count_d = drop_count_q + DROP_ONE;
    end
  end

  // FSM state and training counters.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      stable_cnt_q <= '0;
      timer_q      <= '0;
      retries_q    <= '0;
      retrain_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      timer_q      <= timer_d;
      retries_q    <= retries_d;
      retrain_q    <= retrain_d;
    end
  end

  // Registered TX valid and saturating drop counter.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      valid_tx_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      valid_tx_q   <= valid_tx_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Status outputs are pure decodes of registers; no input reaches an output combinationally.
  assign lnk.link_up    = (state_q == ST_UP);
  assign lnk.link_fail  = (state_q == ST_FAIL);
  assign lnk.state      = state_q;
  assign lnk.retrain    = retrain_q;
  assign lnk.valid_tx   = valid_tx_q;
  assign lnk.drop_count = drop_count_q;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Purpose: self-checking bench for phy_link_ctrl: directed bring-up/recovery/priority steps plus random traffic.
// Latency: outputs compared 1 time unit after each rising clk_f edge against a behavioural model.
// Backpressure: not applicable; valid is driven freely.
module tb_phy_link_ctrl;

  localparam int SC  = 8;
  localparam int RC  = 16;
  localparam int MR  = 3;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  localparam int M_IDLE = 0, M_WAIT = 1, M_STABLE = 2, M_UP = 3, M_RECOVER = 4, M_FAIL = 5;

  logic clk_f;
  logic reset;

  phy_link_ctrl_if #(.CNT_W(CW)) bus ();

  phy_link_ctrl #(
    .STABLE_CYCLES (SC),
    .RECOVER_CYCLES(RC),
    .MAX_RETRIES   (MR),
    .CNT_W         (CW)
  ) dut (
    .clk_f(clk_f),
    .reset(reset),
    .lnk  (bus.slave)
  );

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  int total = 0;
  int bad   = 0;

  // Behavioural model: run = consecutive both-high samples during qualification,
  // age = edges spent in recovery since the lane was lost.
  int m_state, m_run, m_age, m_drop;
  bit m_vtx, m_retrain;
  bit seen_retrain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_run = 0; m_age = 0; m_drop = 0; m_vtx = 0; m_retrain = 0;
  endtask

  task automatic model_step();
    bit both;
    both = bus.active_serial_paralelo_0 & bus.active_serial_paralelo_1;
    m_vtx = bus.valid && (m_state == M_UP);
    if (bus.valid && m_state != M_UP && m_drop < SAT) m_drop++;
    m_retrain = 0;
    if (!bus.train_en) begin
      m_state = M_IDLE; m_run = 0; m_age = 0;
    end else begin
      case (m_state)
        M_IDLE: m_state = M_WAIT;
        M_WAIT: if (both) begin m_state = M_STABLE; m_run = 1; end
        M_STABLE: begin
          if (!both) begin m_state = M_WAIT; m_run = 0; end
          else begin
            m_run++;
            if (m_run == SC) m_state = M_UP;
          end
        end
        M_UP: if (!both) begin m_state = M_RECOVER; m_age = 0; m_retrain = 1; end
        M_RECOVER: begin
          if (both) begin m_state = M_STABLE; m_run = 1; end
          else begin
            m_age++;
            if (m_age == RC * MR) m_state = M_FAIL;
            else if (m_age % RC == 0) m_retrain = 1;
          end
        end
        default: m_state = m_state;
      endcase
    end
  endtask

  task automatic check_all();
    chk("state",      32'(bus.state),      32'(m_state));
    chk("link_up",    32'(bus.link_up),    32'(m_state == M_UP));
    chk("link_fail",  32'(bus.link_fail),  32'(m_state == M_FAIL));
    chk("retrain",    32'(bus.retrain),    32'(m_retrain));
    chk("valid_tx",   32'(bus.valid_tx),   32'(m_vtx));
    chk("drop_count", 32'(bus.drop_count), 32'(m_drop));
  endtask

  task automatic tick();
    @(posedge clk_f);
    model_step();
    #1;
    if (bus.retrain === 1'b1) seen_retrain = 1;
    check_all();
  endtask

  task automatic set_lanes(input bit a0, input bit a1);
    bus.active_serial_paralelo_0 = a0;
    bus.active_serial_paralelo_1 = a1;
  endtask

  // Ticks until link_up is seen; n is the number of edges taken (bounded).
  task automatic wait_up(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.link_up !== 1'b1 && n < 60);
    if (bus.link_up !== 1'b1) chk("wait_up_timeout", 32'(bus.link_up), 32'd1);
  endtask

  initial begin
    int n, off, pulses, pulse_sum, last_pulse;

    reset        = 1'b1;
    bus.train_en = 1'b0;
    set_lanes(0, 0);
    bus.valid    = 1'b1;
    model_reset();
    #2;
    check_all();
    chk("reset_link_up", 32'(bus.link_up), 32'd0);
    #10 reset = 1'b0;

    // Data gating / drop counting: valid held high from reset.
    for (int i = 0; i < 8; i++) tick();
    chk("drop_after_idle", 32'(bus.drop_count), 32'd8);

    // Bring-up: train_en before edge 0, both high from edge 1.
    seen_retrain = 0;
    bus.train_en = 1'b1;
    tick();
    chk("wait_after_edge0", 32'(bus.state), 32'd1);
    set_lanes(1, 1);
    wait_up(n);
    chk("bringup_edges", 32'(n), 32'd8);
    chk("bringup_state", 32'(bus.state), 32'd3);
    chk("bringup_no_retrain", 32'(seen_retrain), 32'd0);
    chk("drop_saturated", 32'(bus.drop_count), 32'(SAT));
    tick();
    chk("valid_tx_after_up", 32'(bus.valid_tx), 32'd1);

    // Glitch during qualification.
    bus.train_en = 1'b0;
    tick();
    chk("idle_on_train_off", 32'(bus.state), 32'd0);
    bus.train_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("stable_before_glitch", 32'(bus.state), 32'd2);
    set_lanes(1, 0);
    tick();
    chk("glitch_to_wait", 32'(bus.state), 32'd1);
    set_lanes(1, 1);
    wait_up(n);
    chk("glitch_requal_edges", 32'(n), 32'd8);

    // Recovery success: active_0 low for 5 samples.
    set_lanes(0, 1);
    tick();
    chk("drop_retrain", 32'(bus.retrain), 32'd1);
    chk("drop_state", 32'(bus.state), 32'd4);
    chk("valid_tx_lags_down", 32'(bus.valid_tx), 32'd1);
    tick();
    chk("retrain_one_cycle", 32'(bus.retrain), 32'd0);
    chk("valid_tx_off", 32'(bus.valid_tx), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    set_lanes(1, 1);
    tick();
    chk("recover_to_stable", 32'(bus.state), 32'd2);
    wait_up(n);
    chk("recover_requal_edges", 32'(n + 1), 32'd8);

    // Retry exhaustion.
    set_lanes(0, 1);
    off = 0; pulses = 0; pulse_sum = 0; last_pulse = -1;
    tick();
    if (bus.retrain === 1'b1) begin pulses++; last_pulse = 0; end
    while (bus.link_fail !== 1'b1 && off < 100) begin
      tick();
      off++;
      if (bus.retrain === 1'b1) begin pulses++; pulse_sum += off; last_pulse = off; end
    end
    chk("fail_edges", 32'(off), 32'(RC * MR));
    chk("retry_pulses", 32'(pulses), 32'(MR));
    chk("retry_pulse_sum", 32'(pulse_sum), 32'(RC + 2 * RC));
    chk("last_pulse", 32'(last_pulse), 32'(2 * RC));
    chk("fail_state", 32'(bus.state), 32'd5);
    for (int i = 0; i < 5; i++) tick();
    chk("fail_sticky", 32'(bus.link_fail), 32'd1);
    bus.train_en = 1'b0;
    tick();
    chk("fail_exit_idle", 32'(bus.state), 32'd0);

    // Priority: train_en drop and lane loss on the same edge.
    bus.train_en = 1'b1;
    set_lanes(1, 1);
    wait_up(n);
    bus.train_en = 1'b0;
    set_lanes(0, 1);
    tick();
    chk("prio_idle", 32'(bus.state), 32'd0);
    chk("prio_no_retrain", 32'(bus.retrain), 32'd0);

    // Async reset mid-RECOVER.
    bus.train_en = 1'b1;
    set_lanes(1, 1);
    wait_up(n);
    set_lanes(0, 1);
    tick();
    tick();
    tick();
    chk("pre_reset_recover", 32'(bus.state), 32'd4);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_reset_drop", 32'(bus.drop_count), 32'd0);
    #2 reset = 1'b0;

    // Random traffic against the model, with periodic long lane outages.
    for (int i = 0; i < 1500; i++) begin
      bus.train_en = ($urandom_range(0, 63) != 0);
      bus.valid    = $urandom_range(0, 1) == 1;
      if ((i % 300) >= 150 && (i % 300) < 215) begin
        set_lanes(0, $urandom_range(0, 1) == 1);
        bus.train_en = 1'b1;
      end else begin
        set_lanes($urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
